time_gen: RTL and testbench
===========================

Name: time_gen

Overview:
Timebase generator that feeds the clock's minute-counting stage. It divides the system clock into a one-second tick and a one-minute tick. Each tick is a single-cycle strobe on the `clk` domain. A fast-watch mode raises the minute tick once per second for demo and test. A synchronous `reset_count` re-aligns the second boundary whenever a new time is loaded, so minutes restart cleanly.

Parameters:
- CLK_PER_SEC, 256, number of `clk` cycles per second; must be >= 2.
- SEC_PER_MIN, 60, number of seconds per minute; must be >= 2.
- PRE_W, $clog2(CLK_PER_SEC), prescaler width; derived, do not override.
- SEC_W, $clog2(SEC_PER_MIN), seconds-counter width; derived, do not override.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- reset_count  input  1  synchronous restart of prescaler and seconds; driven with load_new_c.
- fast_watch  input  1  level; while high, one_minute pulses once per second.
- one_second  output  1  single-cycle strobe, once per CLK_PER_SEC cycles.
- one_minute  output  1  single-cycle strobe; drives the counting stage's one_minute.
- sec_count  output  SEC_W  current seconds, 0..SEC_PER_MIN-1, for display or debug.

Behaviour:
- Reset (reset_n low, asynchronous): prescaler=0, sec_count=0, one_second=0, one_minute=0. Reset holds while low.
- Reset release: first one_second asserts in the cycle after the CLK_PER_SEC-th rising edge following release.
- Prescaler: +1 on every edge. At CLK_PER_SEC-1 it wraps to 0 and sets sec_tick for one cycle.
- one_second: registered; equals sec_tick. It is high for exactly one cycle, then low for CLK_PER_SEC-1 cycles.
- Seconds counter: +1 on each sec_tick. At SEC_PER_MIN-1 with sec_tick it wraps to 0 and min_tick=1.
- Normal mode (fast_watch=0): one_minute is registered, asserted in the same cycle as the one_second that wraps sec_count to 0. Exactly one pulse per SEC_PER_MIN seconds.
- Fast mode (fast_watch=1): one_minute = one_second, coincident, one pulse per second.
  - sec_count keeps counting normally.
  - The wrap-second pulse is not doubled; at most one pulse per cycle.
- fast_watch changes: sampled on the edge that generates a tick. No glitch or extra pulse on toggle. The next tick follows the new mode.
- reset_count=1 (synchronous): prescaler=0 and sec_count=0 on that edge.
  - one_second and one_minute are forced to 0 on the following cycle, even if a tick was due.
  - reset_count has priority over tick generation.
  - Held high, it keeps both counters at 0 and suppresses all pulses.
- After reset_count deasserts, timing is identical to reset release: the first one_second comes CLK_PER_SEC edges later.
- Strobes never stay high longer than one cycle. one_minute never asserts without one_second in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- Arithmetic: unsigned, wrap by explicit compare, never by width overflow, so non-power-of-two parameters work.

Decomposition:
- Shared package clock_pkg:
  - default constants CLK_PER_SEC_DEF=256 and SEC_PER_MIN_DEF=60;
  - BCD digit typedef (4-bit), shared with the counting stage.
- One natural sub-module, mod_counter, parameterised by MODULUS:
  - inputs: clk, reset_n, clr, en;
  - outputs: count, tc (high when count==MODULUS-1 and en);
  - instantiated twice: the prescaler with en=1, and the seconds counter with en=sec_tick.

Test Plan (CLK_PER_SEC=4, SEC_PER_MIN=3 unless noted):
- Release reset_n at edge 0 -> one_second high in cycles 4, 8, 12 only; one_minute high only in cycle 12; sec_count sequence 0,1,2,0.
- Pulse reset_n low mid-count (prescaler=2, sec_count=1) -> all outputs 0 immediately, without waiting for a clock edge; first one_second 4 edges after release.
- fast_watch=1 from reset -> one_minute high in cycles 4, 8, 12, 16, coincident with one_second, each 1 cycle wide.
- Assert reset_count for 1 cycle in the same cycle a one_second/one_minute tick is due -> no pulse that cycle; sec_count=0; next one_second 4 edges after reset_count deasserts.
- Toggle fast_watch 0->1 at sec_count=1 -> next tick gives one_minute=1; back to 0 -> one_minute only on wrap; never two pulses in one cycle.
- Defaults (256/60), run 2 simulated minutes -> exactly 120 one_second and 2 one_minute pulses, 15360 cycles apart.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-path constants and types.
// Used by the timebase and counting stages.
package clock_pkg;

  localparam int CLK_PER_SEC_DEF = 256;
  localparam int SEC_PER_MIN_DEF = 60;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with sync clear.
// tc marks the enabled wrap cycle.
module mod_counter #(
  parameter  int MODULUS = 4,
  localparam int W       = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // Count up on enable, wrap by compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/time_gen.sv
// Timebase: second and minute strobes.
// Fast-watch makes every second a minute.
module time_gen
  import clock_pkg::*;
#(
  parameter  int CLK_PER_SEC = CLK_PER_SEC_DEF,
  parameter  int SEC_PER_MIN = SEC_PER_MIN_DEF,
  localparam int PRE_W       = $clog2(CLK_PER_SEC),
  localparam int SEC_W       = $clog2(SEC_PER_MIN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_count,
  input  logic             fast_watch,
  output logic             one_second,
  output logic             one_minute,
  output logic [SEC_W-1:0] sec_count
);

  logic             sec_tick;
  logic             min_tick;
  logic [PRE_W-1:0] pre_unused;

  mod_counter #(
    .MODULUS (CLK_PER_SEC)
  ) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reset_count),
    .en      (1'b1),
    .count   (pre_unused),
    .tc      (sec_tick)
  );

  mod_counter #(
    .MODULUS (SEC_PER_MIN)
  ) u_sec (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reset_count),
    .en      (sec_tick),
    .count   (sec_count),
    .tc      (min_tick)
  );

  // Register strobes; restart wins over ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else if (reset_count) begin
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else begin
      one_second <= sec_tick;
      one_minute <= sec_tick & (fast_watch | min_tick);
    end
  end

endmodule

// File: tb/tb_time_gen.sv
// Bench for time_gen: small-parameter instance
// against a model, plus a full-size instance.
module tb_time_gen;

  localparam int CPS = 4;
  localparam int SPM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n = 1'b0;
  logic       a_rc    = 1'b0;
  logic       a_fw    = 1'b0;
  logic       a_os;
  logic       a_om;
  logic [1:0] a_sc;

  logic       b_rst_n = 1'b0;
  logic       b_rc    = 1'b0;
  logic       b_fw    = 1'b0;
  logic       b_os;
  logic       b_om;
  logic [5:0] b_sc;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;
  bit b_done   = 1'b0;

  time_gen #(
    .CLK_PER_SEC (CPS),
    .SEC_PER_MIN (SPM)
  ) dut_a (
    .clk         (clk),
    .reset_n     (a_rst_n),
    .reset_count (a_rc),
    .fast_watch  (a_fw),
    .one_second  (a_os),
    .one_minute  (a_om),
    .sec_count   (a_sc)
  );

  time_gen dut_b (
    .clk         (clk),
    .reset_n     (b_rst_n),
    .reset_count (b_rc),
    .fast_watch  (b_fw),
    .one_second  (b_os),
    .one_minute  (b_om),
    .sec_count   (b_sc)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: n = edges since last alignment point
  int n    = 0;
  int e_os = 0;
  int e_om = 0;
  int e_sc = 0;

  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n || a_rc) begin
      n    = 0;
      e_os = 0;
      e_om = 0;
      e_sc = 0;
    end else begin
      n    = n + 1;
      e_os = (n % CPS == 0) ? 1 : 0;
      e_sc = (n / CPS) % SPM;
      e_om = (e_os == 1 && (a_fw || e_sc == 0)) ? 1 : 0;
    end
  end

  // Compare DUT to model every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("model_one_second", int'(a_os), e_os);
      chk("model_one_minute", int'(a_om), e_om);
      chk("model_sec_count", int'(a_sc), e_sc);
    end
  end

  // Full-size instance: two simulated minutes
  initial begin
    int ns;
    int nm;
    int m0;
    int m1;
    ns = 0;
    nm = 0;
    m0 = -1;
    m1 = -1;
    repeat (2) @(negedge clk);
    #1 b_rst_n = 1'b1;
    for (int e = 1; e <= 30730; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_os) ns++;
      if (b_om) begin
        nm++;
        if (m0 < 0) m0 = e;
        else if (m1 < 0) m1 = e;
        if (!b_os) chk("def_min_without_sec", 1, 0);
      end
    end
    chk("def_sec_pulses", ns, 120);
    chk("def_min_pulses", nm, 2);
    chk("def_first_min_edge", m0, 15360);
    chk("def_min_gap", m1 - m0, 15360);
    chk("def_sec_count_end", int'(b_sc), 0);
    b_done = 1'b1;
  end

  initial begin
    repeat (3) tick();
    started = 1'b1;
    tick();
    chk("rst_one_second", int'(a_os), 0);
    chk("rst_one_minute", int'(a_om), 0);
    chk("rst_sec_count", int'(a_sc), 0);

    // Normal run from release
    #1 a_rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) chk("t1_e3_os", int'(a_os), 0);
      if (k == 4) begin
        chk("t1_e4_os", int'(a_os), 1);
        chk("t1_e4_om", int'(a_om), 0);
        chk("t1_e4_sc", int'(a_sc), 1);
      end
      if (k == 8) chk("t1_e8_sc", int'(a_sc), 2);
      if (k == 12) begin
        chk("t1_e12_os", int'(a_os), 1);
        chk("t1_e12_om", int'(a_om), 1);
        chk("t1_e12_sc", int'(a_sc), 0);
      end
      if (k == 13) chk("t1_e13_os", int'(a_os), 0);
    end

    // Async reset mid-count
    repeat (5) tick();
    chk("t2_pre_sc", int'(a_sc), 1);
    #1 a_rst_n = 1'b0;
    #1;
    chk("t2_async_sc", int'(a_sc), 0);
    chk("t2_async_os", int'(a_os), 0);
    repeat (2) tick();
    #1 a_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk("t2_e3_os", int'(a_os), 0);
      if (k == 4) chk("t2_e4_os", int'(a_os), 1);
    end

    // Fast watch from reset
    #1 a_rst_n = 1'b0;
    a_fw = 1'b1;
    tick();
    #1 a_rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k % 4 == 0) begin
        chk("t3_fast_om", int'(a_om), 1);
        chk("t3_fast_os", int'(a_os), 1);
      end
      if (k == 5) chk("t3_e5_om", int'(a_om), 0);
    end

    // reset_count on a due tick
    repeat (3) tick();
    #1 a_rc = 1'b1;
    tick();
    chk("t4_rc_os", int'(a_os), 0);
    chk("t4_rc_om", int'(a_om), 0);
    chk("t4_rc_sc", int'(a_sc), 0);
    #1 a_rc = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk("t4_e3_os", int'(a_os), 0);
      if (k == 4) chk("t4_e4_om", int'(a_om), 1);
    end

    // reset_count held high
    #1 a_rc = 1'b1;
    repeat (6) begin
      tick();
      chk("t4_hold_os", int'(a_os), 0);
    end
    #1 a_rc = 1'b0;
    a_fw = 1'b0;

    // Mode toggle mid-minute
    repeat (5) tick();
    chk("t5_pre_sc", int'(a_sc), 1);
    #1 a_fw = 1'b1;
    repeat (3) tick();
    chk("t5_fast_om", int'(a_om), 1);
    chk("t5_fast_sc", int'(a_sc), 2);
    #1 a_fw = 1'b0;
    repeat (4) tick();
    chk("t5_wrap_om", int'(a_om), 1);
    chk("t5_wrap_sc", int'(a_sc), 0);
    repeat (4) tick();
    chk("t5_norm_os", int'(a_os), 1);
    chk("t5_norm_om", int'(a_om), 0);

    wait (b_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
